fft_addr_sequencer: RTL and testbench

//  Sequences an in-place radix-2 DIT FFT over the shared complex RAM (two read + two write ports).
//  - Issues one butterfly per cycle: read address pair, twiddle index, delayed write-back pair.
//  - Drives fft_busy, which hands RAM ownership to the compute path in the RAM arbiter.
//  - Sits between top-level control and the arbiter's fft_* ports; data is already bit-reversed by I/O.

---
 rtl/fft_pkg.sv | 41 ++++
 rtl/fft_addr_sequencer_if.sv | 51 +++++
 rtl/fft_addr_delay_line.sv | 50 +++++
 rtl/fft_addr_sequencer.sv | 133 +++++++++++++
 tb/tb_fft_addr_sequencer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT address sequencer.
// Holds the FSM state encoding, default sizing, and the butterfly
// address/twiddle calculation used by the sequencer.
package fft_pkg;

  localparam int FFT_N_DEFAULT            = 32;
  localparam int FFT_AW_DEFAULT           = $clog2(FFT_N_DEFAULT);
  localparam int FFT_BFLY_LATENCY_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Fields are kept 32 bits wide so one function serves every FFT size;
  // callers truncate to their own address width.
  typedef struct packed {
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic [31:0] twiddle;
  } bfly_addr_t;

  // Butterfly b of stage s for an FFT of 2**l points: the top leg sits in
  // group b>>s with offset b&(half-1), the bottom leg is half further on.
  function automatic bfly_addr_t bfly_addr(input logic [31:0] b,
                                           input logic [31:0] s,
                                           input logic [31:0] l);
    bfly_addr_t  r;
    logic [31:0] half;
    logic [31:0] pos;
    half      = 32'd1 << s;
    pos       = b & (half - 32'd1);
    r.addr1   = ((b >> s) << (s + 32'd1)) | pos;
    r.addr2   = r.addr1 | half;
    r.twiddle = pos << (l - 32'd1 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_sequencer_if.sv
// Bus between the FFT address sequencer and the top-level control /
// RAM arbiter. The master modport is the sequencer side.
// Optional macro FFT_SEQ_ABORT_EN adds the abort request line.
interface fft_addr_sequencer_if
  import fft_pkg::*;
#(
  parameter int address_width = FFT_AW_DEFAULT
) ();

  localparam int STAGE_W = $clog2(address_width);

  logic                     start;
`ifdef FFT_SEQ_ABORT_EN
  logic                     abort;
`endif
  logic                     fft_busy;
  logic                     fft_read_en;
  logic [address_width-1:0] fft_rd_address1;
  logic [address_width-1:0] fft_rd_address2;
  logic [address_width-2:0] twiddle_idx;
  logic                     fft_wr_en;
  logic [address_width-1:0] fft_wr_address1;
  logic [address_width-1:0] fft_wr_address2;
  logic [STAGE_W-1:0]       stage;
  logic                     done;

`ifdef FFT_SEQ_ABORT_EN
  modport master (
    input  start, abort,
    output fft_busy, fft_read_en, fft_rd_address1, fft_rd_address2, twiddle_idx,
           fft_wr_en, fft_wr_address1, fft_wr_address2, stage, done
  );
  modport slave (
    output start, abort,
    input  fft_busy, fft_read_en, fft_rd_address1, fft_rd_address2, twiddle_idx,
           fft_wr_en, fft_wr_address1, fft_wr_address2, stage, done
  );
`else
  modport master (
    input  start,
    output fft_busy, fft_read_en, fft_rd_address1, fft_rd_address2, twiddle_idx,
           fft_wr_en, fft_wr_address1, fft_wr_address2, stage, done
  );
  modport slave (
    output start,
    input  fft_busy, fft_read_en, fft_rd_address1, fft_rd_address2, twiddle_idx,
           fft_wr_en, fft_wr_address1, fft_wr_address2, stage, done
  );
`endif

endinterface

// File: rtl/fft_addr_delay_line.sv
// Valid+data shift register of configurable depth with synchronous clear.
// Carries read addresses forward so they come back out as write-back
// addresses once the butterfly result is ready.
module fft_addr_delay_line
  import fft_pkg::*;
#(
  parameter int DEPTH = FFT_BFLY_LATENCY_DEFAULT,
  parameter int WIDTH = 2 * FFT_AW_DEFAULT
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             drains_next
);

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Shift every entry one slot toward the output; clear empties the line.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // With no new input, the line is empty after the next shift when only the
  // output slot (or nothing) currently holds a valid entry.
  generate
    if (DEPTH > 1) begin : g_multi
      assign drains_next = ~|valid_q[DEPTH-2:0];
    end else begin : g_single
      assign drains_next = 1'b1;
    end
  endgenerate

endmodule

// File: rtl/fft_addr_sequencer.sv
// In-place radix-2 DIT FFT address sequencer. Issues one butterfly per
// cycle (read pair + twiddle), returns the write pair BFLY_LATENCY cycles
// later, and drains between stages so no stage reads data still in flight.
// Optional macro FFT_SEQ_ABORT_EN adds an abort input that cancels a run.
module fft_addr_sequencer
  import fft_pkg::*;
#(
  parameter int N             = FFT_N_DEFAULT,
  parameter int address_width = $clog2(N),
  parameter int BFLY_LATENCY  = FFT_BFLY_LATENCY_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  fft_addr_sequencer_if.master bus
);

  localparam int BW      = address_width - 1;
  localparam int TW_W    = address_width - 1;
  localparam int STAGE_W = $clog2(address_width);
  localparam int LINE_W  = 2 * address_width;

  localparam logic [BW-1:0]      B_LAST     = '1;
  localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(address_width - 1);

  state_t               state_q, state_d;
  logic [BW-1:0]        b_q, b_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic                 rd_en;
  logic                 abort_hit;
  bfly_addr_t           cur;
  logic [address_width-1:0] rd_addr1, rd_addr2;
  logic [TW_W-1:0]      rd_twiddle;
  logic                 line_out_valid, line_drains_next;
  logic [LINE_W-1:0]    line_out_data;

`ifdef FFT_SEQ_ABORT_EN
  assign abort_hit = bus.abort && ((state_q == RUN) || (state_q == DRAIN));
`else
  assign abort_hit = 1'b0;
`endif

  assign cur        = bfly_addr(32'(b_q), 32'(stage_q), 32'(address_width));
  assign rd_addr1   = address_width'(cur.addr1);
  assign rd_addr2   = address_width'(cur.addr2);
  assign rd_twiddle = TW_W'(cur.twiddle);

  // State, butterfly counter and stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      b_q     <= '0;
      stage_q <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
    end
  end

  // Next-state logic: RUN issues N/2 butterflies, DRAIN waits for the
  // write-back line to empty, then either starts the next stage or finishes.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        b_d     = '0;
        stage_d = '0;
        if (bus.start) state_d = RUN;
      end
      RUN: begin
        rd_en = 1'b1;
        if (b_q == B_LAST) begin
          state_d = DRAIN;
          b_d     = '0;
        end else begin
          b_d = b_q + BW'(1);
        end
      end
      DRAIN: begin
        if (line_drains_next) begin
          if (stage_q == STAGE_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + STAGE_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      b_d     = '0;
      stage_d = '0;
      rd_en   = 1'b0;
    end
  end

  fft_addr_delay_line #(
    .DEPTH (BFLY_LATENCY),
    .WIDTH (LINE_W)
  ) u_wb_line (
    .clk         (clk),
    .clear       (reset || abort_hit),
    .in_valid    (rd_en),
    .in_data     ({rd_addr1, rd_addr2}),
    .out_valid   (line_out_valid),
    .out_data    (line_out_data),
    .drains_next (line_drains_next)
  );

  // Output decode; idle address lines are forced to zero.
  always_comb begin
    bus.fft_busy        = (state_q != IDLE);
    bus.fft_read_en     = rd_en;
    bus.fft_rd_address1 = rd_en ? rd_addr1 : '0;
    bus.fft_rd_address2 = rd_en ? rd_addr2 : '0;
    bus.twiddle_idx     = rd_en ? rd_twiddle : '0;
    bus.fft_wr_en       = line_out_valid && !abort_hit;
    bus.fft_wr_address1 = bus.fft_wr_en ? line_out_data[LINE_W-1 -: address_width] : '0;
    bus.fft_wr_address2 = bus.fft_wr_en ? line_out_data[address_width-1:0] : '0;
    bus.stage           = stage_q;
    bus.done            = (state_q == DONE);
  end

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Self-checking bench for fft_addr_sequencer with N=8, BFLY_LATENCY=3.
// Expected read/write transactions are pushed to scoreboard queues when a
// run is started and popped as the DUT presents them.
// With FFT_SEQ_ABORT_EN defined, an abort scenario is also exercised.
module tb_fft_addr_sequencer;

  localparam int N          = 8;
  localparam int AW         = 3;
  localparam int L          = 3;
  localparam int LAT        = 3;
  localparam int STAGE_COST = N / 2 + LAT;
  localparam int RUN_LEN    = L * STAGE_COST;

  typedef struct {
    int            cyc;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic [AW-2:0] tw;
  } xact_t;

  logic  clk = 1'b0;
  logic  reset;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    run_base = 0;
  logic  run_active = 1'b0;
  int    done_count = 0;
  xact_t rd_q[$];
  xact_t wr_q[$];

  fft_addr_sequencer_if #(.address_width(AW)) bus ();

  fft_addr_sequencer #(
    .N            (N),
    .BFLY_LATENCY (LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic s, input logic r);
    bus.start = s;
    reset     = r;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      $error("[TB] check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Independent model: stage s has groups of 2*half points; leg offset j.
  task automatic pushRun(input int base);
    xact_t e;
    int    half;
    for (int s = 0; s < L; s++) begin
      half = 1 << s;
      for (int g = 0; g < N / (2 * half); g++) begin
        for (int j = 0; j < half; j++) begin
          e.cyc = base + s * STAGE_COST + g * half + j;
          e.a1  = AW'(g * 2 * half + j);
          e.a2  = AW'(g * 2 * half + j + half);
          e.tw  = (AW-1)'(j * (N / (2 * half)));
          rd_q.push_back(e);
          e.cyc = e.cyc + LAT;
          e.tw  = '0;
          wr_q.push_back(e);
        end
      end
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"},  32'(bus.fft_busy), 0);
    checkOutput({tag, "_rd_en"}, 32'(bus.fft_read_en), 0);
    checkOutput({tag, "_rd_a1"}, 32'(bus.fft_rd_address1), 0);
    checkOutput({tag, "_rd_a2"}, 32'(bus.fft_rd_address2), 0);
    checkOutput({tag, "_tw"},    32'(bus.twiddle_idx), 0);
    checkOutput({tag, "_wr_en"}, 32'(bus.fft_wr_en), 0);
    checkOutput({tag, "_wr_a1"}, 32'(bus.fft_wr_address1), 0);
    checkOutput({tag, "_wr_a2"}, 32'(bus.fft_wr_address2), 0);
    checkOutput({tag, "_stage"}, 32'(bus.stage), 0);
    checkOutput({tag, "_done"},  32'(bus.done), 0);
  endtask

  task automatic checkCycle();
    xact_t e;
    logic  exp_rd, exp_wr;
    int    rel;
    int    exp_stage;
    logic  exp_busy, exp_done;
    exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == cyc);
    exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
    checkOutput("rd_en", 32'(bus.fft_read_en), 32'(exp_rd));
    if (exp_rd) begin
      e = rd_q.pop_front();
      checkOutput("rd_addr1", 32'(bus.fft_rd_address1), 32'(e.a1));
      checkOutput("rd_addr2", 32'(bus.fft_rd_address2), 32'(e.a2));
      checkOutput("twiddle",  32'(bus.twiddle_idx), 32'(e.tw));
    end
    checkOutput("wr_en", 32'(bus.fft_wr_en), 32'(exp_wr));
    if (exp_wr) begin
      e = wr_q.pop_front();
      checkOutput("wr_addr1", 32'(bus.fft_wr_address1), 32'(e.a1));
      checkOutput("wr_addr2", 32'(bus.fft_wr_address2), 32'(e.a2));
    end
    rel       = cyc - run_base;
    exp_busy  = run_active && rel >= 0 && rel <= RUN_LEN;
    exp_done  = run_active && rel == RUN_LEN;
    exp_stage = 0;
    if (run_active && rel >= 0 && rel < RUN_LEN) exp_stage = rel / STAGE_COST;
    else if (exp_done) exp_stage = L - 1;
    checkOutput("busy",  32'(bus.fft_busy), 32'(exp_busy));
    checkOutput("done",  32'(bus.done), 32'(exp_done));
    checkOutput("stage", 32'(bus.stage), 32'(exp_stage));
    if (bus.done === 1'b1) done_count++;
  endtask

  // Full run started from IDLE; a stray start is pulsed while RUN is active.
  task automatic doFullRun(input string tag);
    applyStimulus(1'b1, 1'b0);
    run_base   = cyc + 1;
    run_active = 1'b1;
    done_count = 0;
    pushRun(run_base);
    for (int k = 0; k < RUN_LEN + 3; k++) begin
      tick();
      checkCycle();
      applyStimulus(k == 2, 1'b0);
    end
    run_active = 1'b0;
    checkOutput({tag, "_rd_left"}, 32'(rd_q.size()), 0);
    checkOutput({tag, "_wr_left"}, 32'(wr_q.size()), 0);
    checkOutput({tag, "_done_count"}, 32'(done_count), 1);
    rd_q.delete();
    wr_q.delete();
  endtask

  initial begin
`ifdef FFT_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    // Reset with start held high: reset must win.
    applyStimulus(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkIdle("reset_start");
    end
    applyStimulus(1'b0, 1'b0);
    tick();
    checkIdle("idle");

    // Full FFT with scoreboard, stray start during RUN.
    doFullRun("run1");
    checkIdle("after_run1");

    // Reset in the middle of stage 1.
    applyStimulus(1'b1, 1'b0);
    run_base   = cyc + 1;
    run_active = 1'b1;
    pushRun(run_base);
    for (int k = 0; k < STAGE_COST + 3; k++) begin
      tick();
      checkCycle();
      applyStimulus(1'b0, k == STAGE_COST + 2);
    end
    run_active = 1'b0;
    rd_q.delete();
    wr_q.delete();
    tick();
    checkIdle("mid_reset");
    applyStimulus(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      checkIdle("post_reset");
    end

`ifdef FFT_SEQ_ABORT_EN
    // Abort in the first DRAIN of stage 0, then a fresh full run.
    applyStimulus(1'b1, 1'b0);
    run_base   = cyc + 1;
    run_active = 1'b1;
    pushRun(run_base);
    for (int k = 0; k < N / 2 + 1; k++) begin
      tick();
      checkCycle();
      applyStimulus(1'b0, 1'b0);
      bus.abort = (k == N / 2);
    end
    run_active = 1'b0;
    rd_q.delete();
    wr_q.delete();
    tick();
    checkIdle("abort");
    bus.abort = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkIdle("post_abort");
    end
    doFullRun("run_after_abort");
`endif

    doFullRun("run2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
